izh_spike_monitor: RTL and testbench
====================================

Name: izh_spike_monitor

Overview:
Downstream stage of the Izhikevich neuron core. Consumes the neuron's spike output and detects rising edges. Measures the inter-spike interval (ISI) in clock cycles and buffers ISIs in a small FIFO that the host pops by handshake. Also reports spikes-per-window as a firing-rate count for the top-level output mux.

Parameters:
ISI_W, 16, ISI counter and FIFO word width; the counter saturates at 2^ISI_W-1.
FIFO_DEPTH, 4, number of ISI entries; must be a power of 2, minimum 2.
WIN_LOG2, 10, rate window length of 2^WIN_LOG2 enabled cycles.

Ports:
clk  in  1  system clock; all logic on the rising edge.
rst_n  in  1  reset; synchronous, active-low.
ena  in  1  design enable; when low, all counters freeze and no events are taken.
clr  in  1  synchronous soft clear; same effect as reset except on spike_d.
spike_in  in  1  spike level from the neuron core.
rd_req  in  1  pop request for the FIFO head.
isi_data  out  ISI_W  FIFO head; 0 when the FIFO is empty.
isi_valid  out  1  FIFO not empty.
overflow  out  1  sticky flag: an ISI was dropped because the FIFO was full.
rate_count  out  8  spike count of the last completed window.
rate_valid  out  1  one-cycle pulse when rate_count updates.

Behaviour:
- Reset (rst_n=0 at a clk edge): all outputs 0; FIFO empty; armed=0; isi_cnt=0; win_cnt=0; spike_cnt=0; spike_d=0.
- Edge detect: spike_d<=spike_in every cycle, regardless of ena. event = ena & spike_in & ~spike_d.
- ISI counter, updated only when ena=1:
  - On event: isi_cnt<=1.
  - Otherwise: isi_cnt<=min(isi_cnt+1, 2^ISI_W-1).
  - The counter saturates and never wraps.
- Push:
  - On event with armed=1, push the pre-update isi_cnt.
  - The first event after reset or clr only sets armed=1 and pushes nothing.
  - Events D cycles apart push the value D. D above saturation pushes 2^ISI_W-1.
- FIFO:
  - Push data becomes visible the cycle after the event; isi_valid rises one cycle after the first push.
  - Pop occurs when rd_req & isi_valid. The next entry appears the following cycle.
  - rd_req while empty is ignored.
  - rd_req works whether ena is 1 or 0.
- FIFO boundary cases:
  - Push while full with no pop in the same cycle: the entry is dropped and overflow<=1.
  - Push and pop in the same cycle while full: both take effect, occupancy is unchanged, no overflow.
  - Push and pop in the same cycle while holding exactly one entry: isi_valid stays 1 and the new entry becomes the head.
- overflow is cleared only by reset or clr.
- Rate window:
  - win_cnt increments on ena cycles and wraps from 2^WIN_LOG2-1 to 0.
  - spike_cnt increments on each event, saturating at 255.
  - On the wrap cycle: rate_count<=sat255(spike_cnt+event), spike_cnt<=0, rate_valid<=1.
  - rate_valid is 0 on every other cycle.
- clr: takes priority over event, push and pop in the same cycle. It empties the FIFO and zeros overflow, armed, isi_cnt, win_cnt, spike_cnt and rate_count. rate_valid is 0 on that cycle.
- Reset mid-operation (reset asserted mid-window or with a partly full FIFO): state is discarded and nothing partial is emitted.
- Latency: event to isi_valid is 1 cycle; window-end cycle to rate_valid is 1 cycle (registered outputs).

Decomposition:
- Shared package izh_pkg holds the ISI_W, FIFO_DEPTH and WIN_LOG2 defaults, the RATE_MAX=255 constant, and a saturating-increment function.
- One sub-module, izh_isi_fifo: a synchronous FIFO of FIFO_DEPTH x ISI_W with read/write pointers carrying an extra wrap bit. Ports: push, pop, din, dout, full, empty, and clr.

Test Plan:
- Three spike pulses with rising edges at cycles 10, 35 and 47 -> FIFO holds 25 then 12, overflow=0. rd_req pops 25 and then 12; isi_valid falls after the second pop.
- spike_in held high for 20 cycles -> exactly one event and no push. A second rising edge 100 cycles after the first -> isi_data=100.
- Six ISIs with no reads, FIFO_DEPTH=4 -> first four are retained in order and overflow=1. A seventh push coinciding with a pop while full -> accepted and overflow unchanged.
- Spikes far enough apart that the gap exceeds 2^ISI_W-1 cycles (WIN_LOG2 reduced to 4 for runtime) -> pushed value is 2^ISI_W-1 (0xFFFF for ISI_W=16).
- WIN_LOG2=4, a spike every 3 cycles -> rate_valid pulses every 16 cycles with rate_count=5 or 6 per window. A spike on the wrap cycle is counted in the ending window.
- Mid-stream: clr=1 with 2 entries queued and overflow=1 -> next cycle isi_valid=0, overflow=0, rate_count=0. The next spike only arms; the following spike pushes the gap. Repeat the check with rst_n=0 in place of clr.

Source files
------------

// File: rtl/izh_spike_monitor_pkg.sv
// rtl/izh_spike_monitor_pkg.sv - shared constants and helpers for the spike monitor
//
// Purpose: default sizing for the ISI path and rate window, the 8-bit rate
// ceiling, and a saturating increment used by the rate counter.
package izh_pkg;

  localparam int ISI_W_DEF      = 16;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int WIN_LOG2_DEF   = 10;

  localparam logic [7:0] RATE_MAX = 8'd255;

  // Adds inc to v, sticking at RATE_MAX instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic inc);
    if (inc && (v != RATE_MAX)) begin
      return v + 8'd1;
    end
    return v;
  endfunction

endpackage

// File: rtl/izh_spike_monitor_if.sv
// rtl/izh_spike_monitor_if.sv - host-side readout interface of the spike monitor
//
// Purpose: bundles the ISI FIFO pop handshake and the rate/overflow status.
// Signals:
//   rd_req     host -> monitor  pop request for the FIFO head
//   isi_data   monitor -> host  FIFO head, 0 when empty
//   isi_valid  monitor -> host  FIFO not empty
//   overflow   monitor -> host  sticky ISI-dropped flag
//   rate_count monitor -> host  spikes in the last completed window
//   rate_valid monitor -> host  one-cycle pulse on rate_count update
interface izh_spike_monitor_if
  import izh_pkg::*;
#(
  parameter int ISI_W = ISI_W_DEF
);

  logic             rd_req;
  logic [ISI_W-1:0] isi_data;
  logic             isi_valid;
  logic             overflow;
  logic [7:0]       rate_count;
  logic             rate_valid;

  modport master (
    output rd_req,
    input  isi_data, isi_valid, overflow, rate_count, rate_valid
  );

  modport slave (
    input  rd_req,
    output isi_data, isi_valid, overflow, rate_count, rate_valid
  );

endinterface

// File: rtl/izh_spike_monitor_isi_fifo.sv
// rtl/izh_spike_monitor_isi_fifo.sv - synchronous ISI FIFO with wrap-bit pointers
//
// Purpose: DEPTH x W storage for measured intervals.
// Ports:
//   clk, rst_n  clock and synchronous active-low reset
//   clr         soft clear; empties the FIFO and blocks push/pop that cycle
//   push, din   write request and data; ignored when full unless popping too
//   pop         read request; ignored when empty
//   dout        head entry, 0 when empty
//   full, empty occupancy flags
module izh_isi_fifo
  import izh_pkg::*;
#(
  parameter int W     = ISI_W_DEF,
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

  // One extra MSB on each pointer distinguishes full from empty when the
  // index bits match.
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];

  logic do_push;
  logic do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign do_pop  = pop & ~empty & ~clr;
  // A pop in the same cycle frees the slot the push lands in.
  assign do_push = push & ~clr & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/izh_spike_monitor.sv
// rtl/izh_spike_monitor.sv - ISI measurement, ISI FIFO and firing-rate window
//
// Purpose: detects rising edges of the neuron spike level, measures the
// inter-spike interval in enabled cycles, queues intervals for the host and
// counts spikes per 2^WIN_LOG2-cycle window.
// Ports:
//   clk       system clock
//   rst_n     synchronous active-low reset
//   ena       enable; counters freeze and events are ignored when low
//   clr       synchronous soft clear (spike edge history is kept)
//   spike_in  spike level from the neuron core
//   host      readout interface (rd_req in; isi_data, isi_valid, overflow,
//             rate_count, rate_valid out)
module izh_spike_monitor
  import izh_pkg::*;
#(
  parameter int ISI_W      = ISI_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int WIN_LOG2   = WIN_LOG2_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                clr,
  input  logic                spike_in,
  izh_spike_monitor_if.slave  host
);

  localparam logic [ISI_W-1:0] ISI_MAX = '1;

  logic                spike_d;
  logic                evt;
  logic                armed;
  logic [ISI_W-1:0]    isi_cnt;
  logic [WIN_LOG2-1:0] win_cnt;
  logic [7:0]          spike_cnt;
  logic [7:0]          rate_count;
  logic                rate_valid;
  logic                overflow;
  logic                wrap;
  logic                push;
  logic                fifo_full;
  logic                fifo_empty;
  logic [ISI_W-1:0]    fifo_dout;

  // Edge history survives clr so a level held across a clear is not
  // mistaken for a fresh spike.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      spike_d <= 1'b0;
    end else begin
      spike_d <= spike_in;
    end
  end

  assign evt  = ena & spike_in & ~spike_d;
  assign wrap = ena & (win_cnt == '1);
  // The first event after reset/clr only arms; it has no predecessor.
  assign push = evt & armed & ~clr;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      armed      <= 1'b0;
      isi_cnt    <= '0;
      win_cnt    <= '0;
      spike_cnt  <= '0;
      rate_count <= '0;
      rate_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      rate_valid <= 1'b0;
      if (ena) begin
        win_cnt <= win_cnt + WIN_LOG2'(1);
        if (evt) begin
          armed   <= 1'b1;
          isi_cnt <= ISI_W'(1);
        end else if (isi_cnt != ISI_MAX) begin
          isi_cnt <= isi_cnt + ISI_W'(1);
        end
        if (wrap) begin
          // A spike on the wrap cycle belongs to the window that is closing.
          rate_count <= sat_inc(spike_cnt, evt);
          spike_cnt  <= '0;
          rate_valid <= 1'b1;
        end else begin
          spike_cnt <= sat_inc(spike_cnt, evt);
        end
      end
      // Full implies non-empty, so rd_req alone means a pop is freeing a slot.
      if (push && fifo_full && !host.rd_req) begin
        overflow <= 1'b1;
      end
    end
  end

  izh_isi_fifo #(
    .W     (ISI_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .push  (push),
    .pop   (host.rd_req),
    .din   (isi_cnt),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign host.isi_data   = fifo_dout;
  assign host.isi_valid  = ~fifo_empty;
  assign host.overflow   = overflow;
  assign host.rate_count = rate_count;
  assign host.rate_valid = rate_valid;

endmodule

// File: tb/tb_izh_spike_monitor.sv
// tb/tb_izh_spike_monitor.sv - directed self-checking bench for izh_spike_monitor
module tb_izh_spike_monitor;

  logic clk;
  logic rst_n;
  logic ena;
  logic clr;
  logic spike_in;

  int errors = 0;
  int checks = 0;

  izh_spike_monitor_if #(.ISI_W(16)) hif ();

  izh_spike_monitor #(
    .ISI_W      (16),
    .FIFO_DEPTH (4),
    .WIN_LOG2   (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .clr      (clr),
    .spike_in (spike_in),
    .host     (hif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Rising edge d cycles after the previous one-cycle pulse; optional pop on
  // the event cycle.
  task automatic pulse_gap(input int d, input bit with_pop);
    spike_in = 1'b0;
    tick(d - 1);
    spike_in = 1'b1;
    hif.rd_req = with_pop;
    tick(1);
    spike_in = 1'b0;
    hif.rd_req = 1'b0;
  endtask

  task automatic arm();
    spike_in = 1'b1;
    tick(1);
    spike_in = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input int exp);
    check({tag, "_valid"}, 32'(hif.isi_valid), 32'd1);
    check(tag, 32'(hif.isi_data), 32'(exp));
    hif.rd_req = 1'b1;
    tick(1);
    hif.rd_req = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
  endtask

  int exp_rate [3] = '{6, 5, 5};

  initial begin
    rst_n = 1'b0;
    ena = 1'b1;
    clr = 1'b0;
    spike_in = 1'b0;
    hif.rd_req = 1'b0;
    tick(3);
    check("rst_valid", 32'(hif.isi_valid), 32'd0);
    check("rst_data", 32'(hif.isi_data), 32'd0);
    check("rst_ovf", 32'(hif.overflow), 32'd0);
    check("rst_rate", 32'(hif.rate_count), 32'd0);
    check("rst_rate_valid", 32'(hif.rate_valid), 32'd0);
    rst_n = 1'b1;

    // Gaps of 25 and 12
    arm();
    check("t1_arm_only", 32'(hif.isi_valid), 32'd0);
    pulse_gap(25, 1'b0);
    check("t1_first_valid", 32'(hif.isi_valid), 32'd1);
    check("t1_first_data", 32'(hif.isi_data), 32'd25);
    pulse_gap(12, 1'b0);
    check("t1_head", 32'(hif.isi_data), 32'd25);
    check("t1_ovf", 32'(hif.overflow), 32'd0);
    pop_expect("t1_pop0", 25);
    pop_expect("t1_pop1", 12);
    check("t1_empty", 32'(hif.isi_valid), 32'd0);
    check("t1_empty_data", 32'(hif.isi_data), 32'd0);

    // Held-high level gives one event; next edge 100 cycles later
    do_clr();
    spike_in = 1'b1;
    tick(20);
    check("t2_held_nopush", 32'(hif.isi_valid), 32'd0);
    spike_in = 1'b0;
    tick(80);
    spike_in = 1'b1;
    tick(1);
    spike_in = 1'b0;
    pop_expect("t2_isi100", 100);
    check("t2_empty", 32'(hif.isi_valid), 32'd0);

    // Empty pop ignored; push+pop while full with clean overflow
    do_clr();
    hif.rd_req = 1'b1;
    tick(1);
    hif.rd_req = 1'b0;
    check("t3_empty_pop", 32'(hif.isi_valid), 32'd0);
    arm();
    for (int g = 3; g <= 6; g++) pulse_gap(g, 1'b0);
    check("t3_full_noovf", 32'(hif.overflow), 32'd0);
    check("t3_full_head", 32'(hif.isi_data), 32'd3);
    pulse_gap(7, 1'b1);
    check("t3_pushpop_ovf", 32'(hif.overflow), 32'd0);
    pop_expect("t3_pop4", 4);
    pop_expect("t3_pop5", 5);
    pop_expect("t3_pop6", 6);
    pop_expect("t3_pop7", 7);
    check("t3_drained", 32'(hif.isi_valid), 32'd0);

    // Six ISIs without reads, then push+pop while full
    do_clr();
    arm();
    for (int g = 3; g <= 8; g++) pulse_gap(g, 1'b0);
    check("t4_ovf", 32'(hif.overflow), 32'd1);
    check("t4_head", 32'(hif.isi_data), 32'd3);
    pulse_gap(9, 1'b1);
    check("t4_ovf_sticky", 32'(hif.overflow), 32'd1);
    pop_expect("t4_pop4", 4);
    pop_expect("t4_pop5", 5);

    // Soft clear with two queued entries and overflow set
    do_clr();
    check("t5_valid", 32'(hif.isi_valid), 32'd0);
    check("t5_data", 32'(hif.isi_data), 32'd0);
    check("t5_ovf", 32'(hif.overflow), 32'd0);
    check("t5_rate", 32'(hif.rate_count), 32'd0);
    check("t5_rate_valid", 32'(hif.rate_valid), 32'd0);
    arm();
    check("t5_arm_only", 32'(hif.isi_valid), 32'd0);
    pulse_gap(7, 1'b0);
    check("t5_gap", 32'(hif.isi_data), 32'd7);

    // Same again with reset in place of clr
    for (int k = 0; k < 4; k++) pulse_gap(2, 1'b0);
    check("t6_ovf", 32'(hif.overflow), 32'd1);
    pop_expect("t6_pop7", 7);
    pop_expect("t6_pop2", 2);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    check("t6_valid", 32'(hif.isi_valid), 32'd0);
    check("t6_ovf_clr", 32'(hif.overflow), 32'd0);
    check("t6_rate", 32'(hif.rate_count), 32'd0);
    arm();
    check("t6_arm_only", 32'(hif.isi_valid), 32'd0);
    pulse_gap(11, 1'b0);
    check("t6_gap", 32'(hif.isi_data), 32'd11);

    // ena low: spike ignored, counter frozen, pop still works
    ena = 1'b0;
    spike_in = 1'b1;
    tick(1);
    spike_in = 1'b0;
    tick(1);
    hif.rd_req = 1'b1;
    tick(1);
    hif.rd_req = 1'b0;
    check("t7_pop_ena0", 32'(hif.isi_valid), 32'd0);
    ena = 1'b1;
    pulse_gap(5, 1'b0);
    check("t7_frozen_gap", 32'(hif.isi_data), 32'd5);

    // Push and pop together with one entry held
    pulse_gap(6, 1'b1);
    check("t8_valid", 32'(hif.isi_valid), 32'd1);
    check("t8_head", 32'(hif.isi_data), 32'd6);
    pop_expect("t8_pop6", 6);
    check("t8_empty", 32'(hif.isi_valid), 32'd0);

    // Saturation of the ISI counter
    do_clr();
    arm();
    pulse_gap(65541, 1'b0);
    pop_expect("t9_sat", 65535);

    // Rate window of 16 cycles, spike every 3 cycles
    do_clr();
    for (int t = 1; t <= 48; t++) begin
      spike_in = ((t % 3) == 1);
      tick(1);
      check("t10_rate_valid", 32'(hif.rate_valid), 32'((t % 16) == 0));
      if ((t % 16) == 0) begin
        check("t10_rate_count", 32'(hif.rate_count), 32'(exp_rate[t/16 - 1]));
      end
    end
    spike_in = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
